mem_port_arbiter: RTL

- Arbitrates one shared single-ported, fixed-latency memory between the pipeline's two requesters: instruction fetch (IF, read-only) and the MEM stage (loads/stores).
- Sequences every access through a small FSM and returns read data with a one-cycle done pulse.
- Drives per-requester stall signals, which the pipeline ORs into its existing PC/IF_ID stall and hold logic.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int PC_W       = 9,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  if_req;
  logic [PC_W-1:0]       if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic [DM_ADDRESS-1:0] dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [2:0]            dm_func3;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_done;
  logic                  dm_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_func3, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, mem_func3
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_func3, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, mem_func3
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and the MEM stage.
// Data wins arbitration unless fetch has waited through MAX_DM_STREAK data grants.
module mem_port_arbiter #(
  parameter int PC_W          = 9,
  parameter int DM_ADDRESS    = 9,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 2,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [2:0] LAT_M1     = 3'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner_dm;
  logic [2:0]            r_cnt;
  logic [3:0]            r_streak;
  logic                  r_if_valid;
  logic                  r_dm_done;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [DM_ADDRESS-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [2:0]            r_mem_func3;

  logic [PC_W-1:0]       w_if_addr;
  logic                  w_if_elig;
  logic                  w_dm_elig;
  logic                  w_grant_if;
  logic                  w_grant_dm;
  logic                  w_capture;

  assign w_if_addr = bus.if_addr;
  // A requester still seeing its completion pulse has not dropped req yet.
  assign w_if_elig = bus.if_req && !r_if_valid;
  assign w_dm_elig = bus.dm_req && !r_dm_done;

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dm_elig && !(w_if_elig && (r_streak == STREAK_MAX))) begin
          w_grant_dm = 1'b1;
          w_next     = S_ISSUE;
        end else if (w_if_elig) begin
          w_grant_if = 1'b1;
          w_next     = S_ISSUE;
        end
      end
      S_ISSUE: w_next = r_mem_we ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_cnt       <= 3'd0;
      r_streak    <= 4'd0;
      r_if_valid  <= 1'b0;
      r_dm_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_func3 <= 3'd0;
    end else begin
      r_state  <= w_next;
      r_mem_en <= w_grant_if || w_grant_dm;
      r_mem_we <= w_grant_dm && bus.dm_we;

      if (w_grant_dm) begin
        r_owner_dm  <= 1'b1;
        r_mem_addr  <= bus.dm_addr;
        r_mem_wdata <= bus.dm_wdata;
        r_mem_func3 <= bus.dm_func3;
      end else if (w_grant_if) begin
        r_owner_dm  <= 1'b0;
        r_mem_addr  <= DM_ADDRESS'(w_if_addr);
        r_mem_func3 <= 3'b010;
      end

      // Read data arrives MEM_LAT cycles after the strobe; count down from ISSUE.
      if (r_state == S_ISSUE) begin
        r_cnt <= LAT_M1;
      end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end

      if (w_capture) begin
        if (r_owner_dm) r_dm_rdata <= bus.mem_rdata;
        else            r_if_rdata <= bus.mem_rdata;
      end

      r_if_valid <= (w_next == S_RESP) && (r_state != S_RESP) && !r_owner_dm;
      r_dm_done  <= (w_next == S_RESP) && (r_state != S_RESP) &&  r_owner_dm;

      if (!bus.if_req || w_grant_if) begin
        r_streak <= 4'd0;
      end else if (w_grant_dm && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_stall  = bus.if_req && !r_if_valid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_done   = r_dm_done;
  assign bus.dm_stall  = bus.dm_req && !r_dm_done;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_func3 = r_mem_func3;

endmodule
